// File: rtl/cfu_arb_pkg.sv
// Shared types and function_id field helpers for the two-requester CFU arbiter.
package cfu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RSP
    } arb_state_e;

    localparam logic [2:0] FUNCT3_MAC = 3'd3;

    function automatic logic [2:0] funct3(input logic [9:0] function_id);
        return function_id[2:0];
    endfunction

    function automatic logic [6:0] funct7(input logic [9:0] function_id);
        return function_id[9:3];
    endfunction

endpackage

// File: rtl/cfu_rr_arb2.sv
// Two-way round-robin pick among requesters that are both requesting and eligible.
module cfu_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       grant_valid_o
);

    logic [1:0] elig;

    assign elig = req_i & mask_i;

    always_comb begin
        grant_valid_o = |elig;
        grant_o       = 1'b0;
        case (elig)
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_i;  // contention: whoever was not served last
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cfu_shared_arbiter.sv
// Shares one CFU port between two requesters, one command in flight, with a
// MAC lock that keeps the accumulator private to one requester until released.
module cfu_shared_arbiter
    import cfu_arb_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_cmd_valid,
    output logic        r0_cmd_ready,
    input  logic [9:0]  r0_cmd_payload_function_id,
    input  logic [31:0] r0_cmd_payload_inputs_0,
    input  logic [31:0] r0_cmd_payload_inputs_1,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_payload_outputs_0,

    input  logic        r1_cmd_valid,
    output logic        r1_cmd_ready,
    input  logic [9:0]  r1_cmd_payload_function_id,
    input  logic [31:0] r1_cmd_payload_inputs_0,
    input  logic [31:0] r1_cmd_payload_inputs_1,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_payload_outputs_0,

    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    output logic [9:0]  m_cmd_payload_function_id,
    output logic [31:0] m_cmd_payload_inputs_0,
    output logic [31:0] m_cmd_payload_inputs_1,
    input  logic        m_rsp_valid,
    output logic        m_rsp_ready,
    input  logic [31:0] m_rsp_payload_outputs_0,

    output logic        lock_active,
    output logic        lock_owner,
    output logic        lock_timeout
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       fid_q, fid_d;
    logic [31:0]      in0_q, in0_d;
    logic [31:0]      in1_q, in1_d;

    logic [1:0]  req;
    logic [1:0]  mask;
    logic        arb_gnt;
    logic        arb_gnt_valid;
    logic [9:0]  sel_fid;
    logic [31:0] sel_in0;
    logic [31:0] sel_in1;
    logic        sel_rsp_ready;
    logic        owner_idle;

    assign req  = {r1_cmd_valid, r0_cmd_valid};
    assign mask = lock_q ? (owner_q ? 2'b10 : 2'b01) : 2'b11;

    cfu_rr_arb2 u_rr_arb (
        .req_i         (req),
        .mask_i        (mask),
        .last_i        (last_q),
        .grant_o       (arb_gnt),
        .grant_valid_o (arb_gnt_valid)
    );

    assign sel_fid       = arb_gnt ? r1_cmd_payload_function_id : r0_cmd_payload_function_id;
    assign sel_in0       = arb_gnt ? r1_cmd_payload_inputs_0 : r0_cmd_payload_inputs_0;
    assign sel_in1       = arb_gnt ? r1_cmd_payload_inputs_1 : r0_cmd_payload_inputs_1;
    assign sel_rsp_ready = grant_q ? r1_rsp_ready : r0_rsp_ready;
    assign owner_idle    = lock_q && !req[owner_q];

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        lock_d       = lock_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        fid_d        = fid_q;
        in0_d        = in0_q;
        in1_d        = in1_q;
        r0_cmd_ready = 1'b0;
        r1_cmd_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        m_cmd_valid  = 1'b0;
        m_rsp_ready  = 1'b0;
        lock_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_gnt_valid) begin
                    r0_cmd_ready = ~arb_gnt;
                    r1_cmd_ready = arb_gnt;
                    grant_d      = arb_gnt;
                    last_d       = arb_gnt;
                    fid_d        = sel_fid;
                    in0_d        = sel_in0;
                    in1_d        = sel_in1;
                    cnt_d        = '0;
                    state_d      = CMD;
                    // A locked arbiter only grants the owner, so a new lock never steals one.
                    if (funct3(sel_fid) == FUNCT3_MAC) begin
                        if (funct7(sel_fid) != 7'd0) begin
                            lock_d  = 1'b1;
                            owner_d = arb_gnt;
                        end
                    end else begin
                        lock_d = 1'b0;
                    end
                end else if (owner_idle && (LOCK_TIMEOUT != 0)) begin
                    if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
                        lock_d       = 1'b0;
                        cnt_d        = '0;
                        lock_timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CMD: begin
                m_cmd_valid = 1'b1;
                if (m_cmd_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                m_rsp_ready  = sel_rsp_ready;
                r0_rsp_valid = ~grant_q & m_rsp_valid;
                r1_rsp_valid = grant_q & m_rsp_valid;
                if (m_rsp_valid && sel_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data is gated so the idle requester and a reset arbiter see zeros.
    assign r0_rsp_payload_outputs_0 = (state_q == RSP && !grant_q) ? m_rsp_payload_outputs_0 : 32'd0;
    assign r1_rsp_payload_outputs_0 = (state_q == RSP && grant_q) ? m_rsp_payload_outputs_0 : 32'd0;

    assign m_cmd_payload_function_id = fid_q;
    assign m_cmd_payload_inputs_0    = in0_q;
    assign m_cmd_payload_inputs_1    = in1_q;
    assign lock_active               = lock_q;
    assign lock_owner                = owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            fid_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
        end else begin
            // NOTE: nonblocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            fid_q   <= fid_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
        end
    end

endmodule

// File: tb/tb_cfu_shared_arbiter.sv
// Scoreboarded bench for cfu_shared_arbiter: directed commands with hand-computed
// responses, a CFU stub, and a second instance with the lock timeout disabled.
module tb_cfu_shared_arbiter;

    typedef struct packed {
        logic [9:0]  fid;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    localparam logic [9:0] F_ADD     = 10'h000;
    localparam logic [9:0] F_MAC_CLR = 10'h00B;
    localparam logic [9:0] F_MAC_ACC = 10'h003;
    localparam logic [9:0] F_OTHER   = 10'h029;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r0_cmd_valid = 1'b0, r1_cmd_valid = 1'b0;
    logic        r0_cmd_ready, r1_cmd_ready;
    logic [9:0]  r0_cmd_payload_function_id = '0, r1_cmd_payload_function_id = '0;
    logic [31:0] r0_cmd_payload_inputs_0 = '0, r0_cmd_payload_inputs_1 = '0;
    logic [31:0] r1_cmd_payload_inputs_0 = '0, r1_cmd_payload_inputs_1 = '0;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic        r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
    logic [31:0] r0_rsp_payload_outputs_0, r1_rsp_payload_outputs_0;
    logic        m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_ready;
    logic [9:0]  m_cmd_payload_function_id;
    logic [31:0] m_cmd_payload_inputs_0, m_cmd_payload_inputs_1, m_rsp_payload_outputs_0;
    logic        lock_active, lock_owner, lock_timeout;

    cfu_shared_arbiter #(.LOCK_TIMEOUT(4)) u_dut (
        .clk(clk), .reset(rst_n),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready),
        .r0_cmd_payload_function_id(r0_cmd_payload_function_id),
        .r0_cmd_payload_inputs_0(r0_cmd_payload_inputs_0), .r0_cmd_payload_inputs_1(r0_cmd_payload_inputs_1),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_payload_outputs_0(r0_rsp_payload_outputs_0),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready),
        .r1_cmd_payload_function_id(r1_cmd_payload_function_id),
        .r1_cmd_payload_inputs_0(r1_cmd_payload_inputs_0), .r1_cmd_payload_inputs_1(r1_cmd_payload_inputs_1),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_payload_outputs_0(r1_rsp_payload_outputs_0),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_payload_function_id(m_cmd_payload_function_id),
        .m_cmd_payload_inputs_0(m_cmd_payload_inputs_0), .m_cmd_payload_inputs_1(m_cmd_payload_inputs_1),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_payload_outputs_0(m_rsp_payload_outputs_0),
        .lock_active(lock_active), .lock_owner(lock_owner), .lock_timeout(lock_timeout)
    );

    // Second instance: timeout disabled, CFU side always ready and responding.
    logic        b_r0_cmd_valid = 1'b0, b_r1_cmd_valid = 1'b0;
    logic        b_r0_cmd_ready, b_r1_cmd_ready, b_r0_rsp_valid, b_r1_rsp_valid;
    logic [31:0] b_r0_rsp_payload, b_r1_rsp_payload;
    logic        b_m_cmd_valid, b_m_rsp_ready;
    logic [9:0]  b_m_fid;
    logic [31:0] b_m_in0, b_m_in1;
    logic        b_lock_active, b_lock_owner, b_lock_timeout;

    cfu_shared_arbiter #(.LOCK_TIMEOUT(0)) u_dut_nt (
        .clk(clk), .reset(rst_n),
        .r0_cmd_valid(b_r0_cmd_valid), .r0_cmd_ready(b_r0_cmd_ready),
        .r0_cmd_payload_function_id(F_MAC_CLR),
        .r0_cmd_payload_inputs_0(32'd1), .r0_cmd_payload_inputs_1(32'd1),
        .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_ready(1'b1), .r0_rsp_payload_outputs_0(b_r0_rsp_payload),
        .r1_cmd_valid(b_r1_cmd_valid), .r1_cmd_ready(b_r1_cmd_ready),
        .r1_cmd_payload_function_id(F_ADD),
        .r1_cmd_payload_inputs_0(32'd2), .r1_cmd_payload_inputs_1(32'd2),
        .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_ready(1'b1), .r1_rsp_payload_outputs_0(b_r1_rsp_payload),
        .m_cmd_valid(b_m_cmd_valid), .m_cmd_ready(1'b1),
        .m_cmd_payload_function_id(b_m_fid),
        .m_cmd_payload_inputs_0(b_m_in0), .m_cmd_payload_inputs_1(b_m_in1),
        .m_rsp_valid(1'b1), .m_rsp_ready(b_m_rsp_ready), .m_rsp_payload_outputs_0(32'd0),
        .lock_active(b_lock_active), .lock_owner(b_lock_owner), .lock_timeout(b_lock_timeout)
    );

    // CFU stub: ADD-like for non-MAC funct3, accumulator MAC for funct3 == 3.
    logic        cfu_cmd_ready_en = 1'b1;
    logic        cfu_rsp_v;
    logic [31:0] cfu_rsp_d, cfu_acc;

    function automatic logic [31:0] cfu_result(input logic [9:0] fid, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] acc);
        if (fid[2:0] == 3'd3) return (fid[9:3] != 7'd0) ? 32'(a * b) : 32'(acc + a * b);
        return a + b;
    endfunction

    assign m_cmd_ready             = cfu_cmd_ready_en;
    assign m_rsp_valid             = cfu_rsp_v;
    assign m_rsp_payload_outputs_0 = cfu_rsp_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfu_rsp_v <= 1'b0;
            cfu_rsp_d <= '0;
            cfu_acc   <= '0;
        end else begin
            if (m_rsp_valid && m_rsp_ready) cfu_rsp_v <= 1'b0;
            if (m_cmd_valid && m_cmd_ready) begin
                cfu_rsp_v <= 1'b1;
                cfu_rsp_d <= cfu_result(m_cmd_payload_function_id, m_cmd_payload_inputs_0,
                                        m_cmd_payload_inputs_1, cfu_acc);
                if (m_cmd_payload_function_id[2:0] == 3'd3)
                    cfu_acc <= cfu_result(m_cmd_payload_function_id, m_cmd_payload_inputs_0,
                                          m_cmd_payload_inputs_1, cfu_acc);
            end
        end
    end

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic id, input logic [9:0] fid, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rsp);
        if (id) q1.push_back('{fid, a, b});
        else    q0.push_back('{fid, a, b});
        exp_q.push_back('{id, rsp});
    endtask

    task automatic score(input logic id, input logic [31:0] data, input logic other_valid);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("rsp_id", id, e.id);
            check("rsp_data", data, e.data);
            check("rsp_other_quiet", other_valid, 1'b0);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Requester drivers: hold valid/payload until accepted, then load the next command.
    initial begin : drv_r0
        logic acc;
        cmd_t c;
        forever begin
            @(negedge clk);
            acc = r0_cmd_valid && r0_cmd_ready;
            @(posedge clk);
            #1;
            if (acc || !r0_cmd_valid) begin
                if (q0.size() != 0) begin
                    c = q0.pop_front();
                    r0_cmd_valid = 1'b1;
                    r0_cmd_payload_function_id = c.fid;
                    r0_cmd_payload_inputs_0 = c.a;
                    r0_cmd_payload_inputs_1 = c.b;
                end else begin
                    r0_cmd_valid = 1'b0;
                end
            end
        end
    end

    initial begin : drv_r1
        logic acc;
        cmd_t c;
        forever begin
            @(negedge clk);
            acc = r1_cmd_valid && r1_cmd_ready;
            @(posedge clk);
            #1;
            if (acc || !r1_cmd_valid) begin
                if (q1.size() != 0) begin
                    c = q1.pop_front();
                    r1_cmd_valid = 1'b1;
                    r1_cmd_payload_function_id = c.fid;
                    r1_cmd_payload_inputs_0 = c.a;
                    r1_cmd_payload_inputs_1 = c.b;
                end else begin
                    r1_cmd_valid = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (r0_rsp_valid && r0_rsp_ready) score(1'b0, r0_rsp_payload_outputs_0, r1_rsp_valid);
            if (r1_rsp_valid && r1_rsp_ready) score(1'b1, r1_rsp_payload_outputs_0, r0_rsp_valid);
        end
    end

    initial begin : stimulus
        int n;
        int viol;

        repeat (3) @(negedge clk);
        check("reset_ctl", {r0_cmd_ready, r1_cmd_ready, r0_rsp_valid, r1_rsp_valid, m_cmd_valid,
                            m_rsp_ready, lock_active, lock_owner, lock_timeout}, 9'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {m_cmd_valid, lock_active, m_cmd_payload_function_id}, 12'd0);

        // Unlocked contention: strict alternation, r0 first.
        issue(1'b0, F_ADD, 32'd1, 32'd2, 32'd3);
        issue(1'b1, F_ADD, 32'd10, 32'd20, 32'd30);
        issue(1'b0, F_ADD, 32'd3, 32'd4, 32'd7);
        issue(1'b1, F_ADD, 32'd30, 32'd40, 32'd70);
        issue(1'b0, F_ADD, 32'd5, 32'd6, 32'd11);
        issue(1'b1, F_ADD, 32'd50, 32'd60, 32'd110);
        wait_drain(200);
        check("alt_no_lock", lock_active, 1'b0);

        // MAC lock holds r1 off until r0's non-MAC command.
        issue(1'b0, F_MAC_CLR, 32'd2, 32'd3, 32'd6);
        issue(1'b0, F_MAC_ACC, 32'd4, 32'd5, 32'd26);
        issue(1'b0, F_ADD, 32'd1, 32'd1, 32'd2);
        issue(1'b1, F_ADD, 32'd7, 32'd8, 32'd15);
        n = 0;
        do begin @(negedge clk); n++; end while (!lock_active && n < 20);
        check("lock_taken", {lock_active, lock_owner}, 2'b10);
        wait_drain(200);
        check("lock_released", lock_active, 1'b0);

        // Owner goes quiet: four idle cycles, pulse, then r1 accepted.
        issue(1'b0, F_MAC_CLR, 32'd1, 32'd1, 32'd1);
        issue(1'b1, F_ADD, 32'd2, 32'd2, 32'd4);
        n = 0;
        do begin @(negedge clk); n++; end while (!(r0_rsp_valid && r0_rsp_ready) && n < 20);
        check("to_owner_rsp_seen", r0_rsp_valid && r0_rsp_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_waiting", {lock_timeout, r1_cmd_ready, lock_active}, 3'b001);
        end
        @(negedge clk);
        check("to_pulse", {lock_timeout, r1_cmd_ready, lock_active}, 3'b101);
        @(negedge clk);
        check("to_grant_r1", {lock_timeout, r1_cmd_ready, lock_active}, 3'b010);
        wait_drain(100);

        // CFU stalls the command, then r0 stalls the response.
        cfu_cmd_ready_en = 1'b0;
        issue(1'b0, F_OTHER, 32'd9, 32'd9, 32'd18);
        issue(1'b1, F_ADD, 32'd1, 32'd0, 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(r0_cmd_valid && r0_cmd_ready) && n < 20);
        check("stall_accept_seen", r0_cmd_valid && r0_cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("stall_cmd", {m_cmd_valid, r0_cmd_ready, r1_cmd_ready}, 3'b100);
            check("stall_payload", {m_cmd_payload_function_id, m_cmd_payload_inputs_0, m_cmd_payload_inputs_1},
                  {F_OTHER, 32'd9, 32'd9});
        end
        @(posedge clk);
        #1;
        cfu_cmd_ready_en = 1'b1;
        r0_rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_cmd_handshake", m_cmd_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rsp_hold", {r0_rsp_valid, m_rsp_ready, r0_cmd_ready, r1_cmd_ready}, 4'b1000);
            check("rsp_hold_data", r0_rsp_payload_outputs_0, 32'd18);
        end
        @(posedge clk);
        #1;
        r0_rsp_ready = 1'b1;
        wait_drain(100);

        // Reset in RSP while locked; the response is dropped, not scored.
        r0_rsp_ready = 1'b0;
        q0.push_back('{F_MAC_CLR, 32'd3, 32'd3});
        n = 0;
        do begin @(negedge clk); n++; end while (!r0_rsp_valid && n < 20);
        check("rst_pre_locked_rsp", {r0_rsp_valid, lock_active}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", {r0_cmd_ready, r1_cmd_ready, r0_rsp_valid, r1_rsp_valid, m_cmd_valid,
                                m_rsp_ready, lock_active, lock_owner, lock_timeout}, 9'd0);
        check("rst_async_data", {m_cmd_payload_function_id, m_cmd_payload_inputs_0, r0_rsp_payload_outputs_0},
              74'd0);
        r0_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, F_ADD, 32'd5, 32'd5, 32'd10);
        issue(1'b1, F_ADD, 32'd6, 32'd6, 32'd12);
        wait_drain(100);

        // Timeout disabled: lock survives 1000 idle owner cycles.
        b_r0_cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_r0_cmd_ready && n < 20);
        check("nt_accept_seen", b_r0_cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        b_r0_cmd_valid = 1'b0;
        b_r1_cmd_valid = 1'b1;
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!b_lock_active || b_lock_timeout || b_r1_cmd_ready) viol++;
        end
        check("nt_violations", viol, 0);
        check("nt_lock_held", {b_lock_active, b_lock_owner}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
